product_accumulator: RTL and testbench

Downstream consumer of the 16x16 unsigned Wallace multiplier's 32-bit product. It accepts one product per cycle through a valid/ready handshake and rescales each product from fixed point. It then adds or subtracts the product into a signed accumulator and, on the last term of a sequence, emits a saturated 16-bit signed result. The ODE solver datapath uses it to form weighted sums (e.g. h·f terms) from unsigned magnitude products plus a separately tracked sign.

---
 rtl/product_accumulator_if.sv | 25 ++
 rtl/product_accumulator.sv | 129 ++++++++++++
 tb/tb_product_accumulator.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Handshake bundle for the product accumulator: the product stream in and the
// saturated result stream out.
interface product_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_product;
  logic        in_neg;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_ovf;
  logic [6:0]  out_count;

  modport master (
    output in_valid, in_product, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_product, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_ovf, out_count
  );
endinterface

// File: rtl/product_accumulator.sv
// Rescales unsigned fixed-point products, adds or subtracts them into a signed
// accumulator, and emits a saturated 16-bit signed sum on the last term.
module product_accumulator #(
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  // Round half-up on the magnitude, then apply the sign.
  function automatic logic signed [ACC_W-1:0] scale_term(input logic [31:0] prod,
                                                         input logic        neg);
    logic [32:0]      rnd;
    logic [ACC_W-1:0] mag;
    rnd = {1'b0, prod} + (33'd1 << (FRAC_BITS - 1));
    rnd = rnd >> FRAC_BITS;
    mag = {{(ACC_W-33){1'b0}}, rnd};
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  // Returns {clipped, data}.
  function automatic logic [16:0] sat16(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return {1'b1, 16'h7FFF};
    else if (a < SAT_MIN) return {1'b1, 16'h8000};
    else                  return {1'b0, a[15:0]};
  endfunction

  state_e                  state_q, state_d;
  logic                    p_vld_q;
  logic [31:0]             p_prod_q;
  logic                    p_neg_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, term, acc_sum;
  logic [6:0]              cnt_q, cnt_d, cnt_inc;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_ovf_q, out_ovf_d;
  logic [6:0]              out_count_q, out_count_d;
  logic [16:0]             sat_res;
  logic                    accept;

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  assign bus.in_ready  = rst_n && (state_q == ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;
  assign term          = scale_term(p_prod_q, p_neg_q);
  assign acc_sum       = acc_q + term;
  assign cnt_inc       = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = p_vld_q ? acc_sum : acc_q;
    cnt_d       = p_vld_q ? cnt_inc : cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    sat_res     = sat16(acc_d);
    case (state_q)
      ACCUM: if (accept && bus.in_last) state_d = FLUSH;
      FLUSH: begin
        // The last term is still in the capture stage; acc_d already includes it.
        out_data_d  = sat_res[15:0];
        out_sat_d   = sat_res[16];
        out_ovf_d   = int'(cnt_d) > MAX_TERMS;
        out_count_d = cnt_d;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Stage 1: capture the accepted term.
  always_ff @(posedge clk) begin
    if (accept) begin
      p_prod_q <= bus.in_product;
      p_neg_q  <= bus.in_neg;
    end
  end

  // Stage 2: accumulate, sequence control and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      p_vld_q     <= accept;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator against an integer
// reference model of the weighted sum.
module tb_product_accumulator;
  localparam int FB = 8;
  localparam int MT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] t_prod[$];
  bit          t_neg[$];

  product_accumulator_if pa_if ();

  product_accumulator #(.FRAC_BITS(FB), .ACC_W(40), .MAX_TERMS(MT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pa_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the queued terms as one sequence, then collect the result after
  // holding out_ready low for 'hold' cycles with junk on the input.
  task automatic run_seq(input string tag, input int hold);
    longint sum = 0;
    longint exp_d;
    bit     exp_s;
    int     n = t_prod.size();
    int     waits;
    logic [15:0] held;
    for (int i = 0; i < n; i++) begin
      longint mag = (longint'(t_prod[i]) + (64'sd1 <<< (FB - 1))) >>> FB;
      sum += t_neg[i] ? -mag : mag;
    end
    exp_s = (sum > 32767) || (sum < -32768);
    exp_d = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
    exp_d = exp_d & 64'hFFFF;

    for (int i = 0; i < n; i++) begin
      pa_if.in_valid   = 1'b1;
      pa_if.in_product = t_prod[i];
      pa_if.in_neg     = t_neg[i];
      pa_if.in_last    = (i == n - 1);
      waits = 0;
      while (!pa_if.in_ready && waits < 20) begin
        tick();
        waits++;
      end
      if (!pa_if.in_ready) chk({tag, "_rdy_timeout"}, 0, 1);
      tick();
    end
    pa_if.in_valid = 1'b0;
    chk({tag, "_vld_early"}, pa_if.out_valid, 0);
    chk({tag, "_rdy_flush"}, pa_if.in_ready, 0);
    tick();
    chk({tag, "_vld"}, pa_if.out_valid, 1);
    chk({tag, "_data"}, pa_if.out_data, exp_d);
    chk({tag, "_sat"}, pa_if.out_sat, exp_s);
    chk({tag, "_ovf"}, pa_if.out_ovf, n > MT);
    chk({tag, "_cnt"}, pa_if.out_count, (n > 127) ? 127 : n);
    held = pa_if.out_data;
    for (int h = 0; h < hold; h++) begin
      pa_if.in_valid   = 1'b1;
      pa_if.in_product = $urandom;
      pa_if.in_neg     = 1'($urandom);
      pa_if.in_last    = 1'($urandom);
      tick();
      chk({tag, "_bp_data"}, pa_if.out_data, held);
      chk({tag, "_bp_vld"}, pa_if.out_valid, 1);
      chk({tag, "_bp_rdy"}, pa_if.in_ready, 0);
    end
    pa_if.out_ready = 1'b1;
    tick();
    pa_if.in_valid  = 1'b0;
    pa_if.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, pa_if.out_valid, 0);
    chk({tag, "_rdy_back"}, pa_if.in_ready, 1);
    t_prod.delete();
    t_neg.delete();
  endtask

  task automatic push(input logic [31:0] p, input bit neg);
    t_prod.push_back(p);
    t_neg.push_back(neg);
  endtask

  initial begin
    pa_if.in_valid   = 1'b0;
    pa_if.in_product = '0;
    pa_if.in_neg     = 1'b0;
    pa_if.in_last    = 1'b0;
    pa_if.out_ready  = 1'b0;
    tick();
    chk("rst_rdy", pa_if.in_ready, 0);
    chk("rst_vld", pa_if.out_valid, 0);
    chk("rst_data", pa_if.out_data, 0);
    chk("rst_cnt", pa_if.out_count, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_rdy", pa_if.in_ready, 1);

    push(32'h0000_0300, 0);
    run_seq("single", 0);

    push(32'h0500, 0); push(32'h0200, 1); push(32'h0180, 0);
    run_seq("round_up", 0);
    push(32'h0500, 0); push(32'h0200, 1); push(32'h017F, 0);
    run_seq("round_dn", 0);

    push(32'h7FFF_0000, 0);
    run_seq("sat_pos", 0);
    push(32'h0100_0000, 1);
    run_seq("sat_neg", 0);

    push(32'h0000_1234, 0); push(32'h0000_0456, 1);
    run_seq("backpr", 5);

    // Two terms accepted, then an asynchronous reset mid-cycle.
    pa_if.in_valid   = 1'b1;
    pa_if.in_product = 32'h0100;
    pa_if.in_neg     = 1'b0;
    pa_if.in_last    = 1'b0;
    tick();
    tick();
    pa_if.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", pa_if.out_data, 0);
    chk("mid_rst_vld", pa_if.out_valid, 0);
    chk("mid_rst_rdy", pa_if.in_ready, 0);
    chk("mid_rst_cnt", pa_if.out_count, 0);
    chk("mid_rst_sat", pa_if.out_sat, 0);
    tick();
    rst_n = 1'b1;
    tick();
    push(32'h0100, 0);
    run_seq("post_rst", 0);

    for (int i = 0; i < 65; i++) push(32'h0100, 0);
    run_seq("overlen", 0);

    for (int s = 0; s < 20; s++) begin
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        push($urandom >> $urandom_range(4, 31), 1'($urandom));
      run_seq($sformatf("rnd%0d", s), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
